// File: rtl/irq_pend_ctrl.sv
// irq_pend_ctrl: request collection and dispatch stage in front of an
// external 8-to-3 priority encoder.
//
// Raw request lines are edge-detected into sticky pending bits.
// The masked pending vector (pend_o) drives the encoder. The encoder's
// Y/V outputs return here, and a two-state FSM latches the winner. It then
// runs an irq/ack handshake with the consumer.
//
// Optional build macro: IRQ_STAT_EN adds a 16-bit dispatch counter on
// output port disp_cnt.

module irq_pend_ctrl #(
  parameter int unsigned NREQ = 8,
  parameter int unsigned IDW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            mask_we,
  input  logic [NREQ-1:0] mask_d,
  output logic [NREQ-1:0] mask_q,
  output logic [NREQ-1:0] pend_o,
  input  logic [IDW-1:0]  enc_y,
  input  logic            enc_v,
  output logic            irq_o,
  output logic [IDW-1:0]  irq_id,
  input  logic            ack_i
`ifdef IRQ_STAT_EN
  ,
  output logic [15:0]     disp_cnt
`endif
);

  localparam int unsigned CNTW = 16;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DISP = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] pend_q,  pend_d;
  logic [NREQ-1:0] msk_q,   msk_d;
  logic [NREQ-1:0] prev_q,  prev_d;
  logic            irq_q,   irq_d;
  logic [IDW-1:0]  id_q,    id_d;

  logic [NREQ-1:0] rise;
  logic [NREQ-1:0] clr;
  logic            ack_acc;

  // Rising-edge detect, pending set/clear (a set beats a same-cycle clear), mask write
  always_comb begin
    rise    = '0;
    clr     = '0;
    ack_acc = 1'b0;
    pend_d  = pend_q;
    prev_d  = prev_q;
    msk_d   = msk_q;

    rise    = req_i & ~prev_q;
    ack_acc = (state_q == S_DISP) && ack_i;
    if (ack_acc) begin
      clr = NREQ'(1) << id_q;
    end
    pend_d = (pend_q & ~clr) | rise;
    prev_d = req_i;
    if (mask_we) begin
      msk_d = mask_d;
    end
  end

  // Dispatch FSM: latch the encoder winner in IDLE, hold it in DISP until ack
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    irq_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enc_v) begin
          id_d    = enc_y;
          state_d = S_DISP;
        end
      end
      S_DISP: begin
        if (ack_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    irq_d = (state_d == S_DISP);
  end

  // State registers; req history resets high so lines held through reset stay quiet
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      msk_q   <= '0;
      prev_q  <= '1;
      irq_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      msk_q   <= msk_d;
      prev_q  <= prev_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
    end
  end

`ifdef IRQ_STAT_EN
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Count accepted acks; wraps naturally at 2**CNTW
  always_comb begin
    cnt_d = cnt_q;
    if (ack_acc) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  // Dispatch counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign disp_cnt = cnt_q;
`endif

  assign mask_q = msk_q;
  assign pend_o = pend_q & ~msk_q;
  assign irq_o  = irq_q;
  assign irq_id = id_q;

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// tb_irq_pend_ctrl: directed and random stimulus checked cycle by cycle
// against a rule-level model of pending/mask/dispatch behaviour.
// The 8-to-3 priority encoder is modelled here and fed from pend_o.

module tb_irq_pend_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_i;
  logic       mask_we;
  logic [7:0] mask_d;
  logic [7:0] mask_q;
  logic [7:0] pend_o;
  logic [2:0] enc_y;
  logic       enc_v;
  logic       irq_o;
  logic [2:0] irq_id;
  logic       ack_i;
`ifdef IRQ_STAT_EN
  logic [15:0] disp_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic [7:0]  m_pend, m_mask, m_prev;
  logic        m_busy;
  logic [2:0]  m_id;
  logic [15:0] m_cnt;

  irq_pend_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .mask_we (mask_we),
    .mask_d  (mask_d),
    .mask_q  (mask_q),
    .pend_o  (pend_o),
    .enc_y   (enc_y),
    .enc_v   (enc_v),
    .irq_o   (irq_o),
    .irq_id  (irq_id),
    .ack_i   (ack_i)
`ifdef IRQ_STAT_EN
    ,
    .disp_cnt(disp_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural priority encoder: bit 7 highest
  always_comb begin
    enc_v = |pend_o;
    enc_y = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pend_o[i]) enc_y = 3'(i);
    end
  end

  function automatic logic [2:0] highest(input logic [7:0] v);
    highest = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) highest = 3'(i);
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the rules on current inputs
  task automatic model_step();
    logic [7:0] rise, clr, vis;
    if (rst) begin
      m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'hFF;
      m_busy = 1'b0;  m_id = 3'd0;    m_cnt = 16'd0;
    end else begin
      rise = req_i & ~m_prev;
      clr  = 8'h00;
      vis  = m_pend & ~m_mask;
      if (m_busy) begin
        if (ack_i) begin
          clr    = 8'h01 << m_id;
          m_busy = 1'b0;
          m_cnt  = m_cnt + 16'd1;
        end
      end else if (vis != 8'h00) begin
        m_busy = 1'b1;
        m_id   = highest(vis);
      end
      m_pend = (m_pend & ~clr) | rise;
      m_prev = req_i;
      if (mask_we) m_mask = mask_d;
    end
  endtask

  // One clock: model update at the edge, compare all outputs on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("pend_o", 16'(pend_o), 16'(m_pend & ~m_mask));
    chk("mask_q", 16'(mask_q), 16'(m_mask));
    chk("irq_o",  16'(irq_o),  16'(m_busy));
    chk("irq_id", 16'(irq_id), 16'(m_id));
`ifdef IRQ_STAT_EN
    chk("disp_cnt", disp_cnt, m_cnt);
`endif
  endtask

  initial begin
    rst = 1'b1; req_i = 8'h81; mask_we = 1'b0; mask_d = 8'h00; ack_i = 1'b0;
    m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'hFF;
    m_busy = 1'b0;  m_id = 3'd0;    m_cnt = 16'd0;

    // Reset with 0x81 held; no events after release
    cycle(); cycle();
    chk("rst_irq", 16'(irq_o), 16'h0);
    chk("rst_mask", 16'(mask_q), 16'h00);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("held_pend", 16'(pend_o), 16'h00);
    chk("held_irq", 16'(irq_o), 16'h0);

    // Single source, 2-cycle latency, hold, ack
    req_i = 8'h00; cycle();
    req_i = 8'h08; cycle();
    chk("b3_pend", 16'(pend_o), 16'h08);
    chk("b3_noirq", 16'(irq_o), 16'h0);
    cycle();
    chk("b3_irq", 16'(irq_o), 16'h1);
    chk("b3_id", 16'(irq_id), 16'h3);
    for (int i = 0; i < 5; i++) cycle();
    chk("b3_hold", 16'(irq_id), 16'h3);
    ack_i = 1'b1; cycle();
    chk("b3_clr", 16'(pend_o), 16'h00);
    chk("b3_drop", 16'(irq_o), 16'h0);
    ack_i = 1'b0;

    // Simultaneous rises on 1,5,6 dispatched 6,5,1 with one-cycle gaps
    req_i = 8'h00; cycle();
    req_i = 8'h62; cycle();
    cycle();
    chk("m_id6", 16'(irq_id), 16'h6);
    ack_i = 1'b1; cycle();
    chk("m_gap1", 16'(irq_o), 16'h0);
    ack_i = 1'b0; cycle();
    chk("m_id5", 16'(irq_id), 16'h5);
    ack_i = 1'b1; cycle();
    chk("m_gap2", 16'(irq_o), 16'h0);
    ack_i = 1'b0; cycle();
    chk("m_id1", 16'(irq_id), 16'h1);
    ack_i = 1'b1; cycle();
    chk("m_done", 16'(pend_o), 16'h00);
    ack_i = 1'b0;

    // No preemption: bit 7 arrives while id 2 dispatched
    req_i = 8'h00; cycle();
    req_i = 8'h04; cycle();
    cycle();
    req_i = 8'h84; cycle();
    chk("np_pend", 16'(pend_o), 16'h84);
    cycle(); cycle();
    chk("np_id2", 16'(irq_id), 16'h2);
    ack_i = 1'b1; cycle();
    ack_i = 1'b0; cycle();
    chk("np_id7", 16'(irq_id), 16'h7);
    ack_i = 1'b1; cycle();
    ack_i = 1'b0;

    // Masked source stays pending, dispatches once unmasked
    req_i = 8'h00; mask_we = 1'b1; mask_d = 8'h10; cycle();
    mask_we = 1'b0;
    chk("mk_mask", 16'(mask_q), 16'h10);
    req_i = 8'h10; cycle();
    chk("mk_hid", 16'(pend_o), 16'h00);
    cycle(); cycle();
    chk("mk_noirq", 16'(irq_o), 16'h0);
    mask_we = 1'b1; mask_d = 8'h00; cycle();
    mask_we = 1'b0;
    chk("mk_vis", 16'(pend_o), 16'h10);
    cycle();
    chk("mk_id4", 16'(irq_id), 16'h4);
    chk("mk_irq", 16'(irq_o), 16'h1);
    ack_i = 1'b1; cycle();
    ack_i = 1'b0;

    // Re-rise of bit 0 in the ack cycle keeps it pending
    req_i = 8'h00; cycle();
    req_i = 8'h01; cycle();
    cycle();
    chk("rr_id0", 16'(irq_id), 16'h0);
    req_i = 8'h00; cycle();
    req_i = 8'h01; ack_i = 1'b1; cycle();
    chk("rr_keep", 16'(pend_o), 16'h01);
    chk("rr_gap", 16'(irq_o), 16'h0);
    ack_i = 1'b0; cycle();
    chk("rr_redisp", 16'(irq_o), 16'h1);
    chk("rr_id0b", 16'(irq_id), 16'h0);
    ack_i = 1'b1; cycle();
    chk("rr_clr", 16'(pend_o), 16'h00);
    ack_i = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      req_i   = 8'($urandom);
      ack_i   = 1'($urandom_range(0, 1));
      mask_we = ($urandom_range(0, 15) == 0);
      mask_d  = 8'($urandom);
      rst     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0; mask_we = 1'b0; ack_i = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
